// File: rtl/rom_arbiter_if.sv
// Bus bundle between the mapper's PRG/CHR ROM channels, the arbiter and the memory controller.
// The slave modport is the arbiter's view; master is the surrounding environment's view.
interface rom_arbiter_if;
  logic [20:0] promaddr;
  logic        promreq;
  logic [7:0]  promdata;
  logic        promack;
  logic [20:0] cromaddr;
  logic        cromreq;
  logic [7:0]  cromdata;
  logic        cromack;
  logic [21:0] romaddr;
  logic        romreq;
  logic [7:0]  romdata;
  logic        romack;
  logic        err;

  modport slave (
    input  promaddr, promreq, cromaddr, cromreq, romdata, romack,
    output promdata, promack, cromdata, cromack, romaddr, romreq, err
  );

  modport master (
    output promaddr, promreq, cromaddr, cromreq, romdata, romack,
    input  promdata, promack, cromdata, cromack, romaddr, romreq, err
  );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one ROM port between the PRG and CHR channels of a mapper.
// Optional request watchdog enabled by defining ROMARB_TIMEOUT_EN (limit set by TIMEOUT).
module rom_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  rom_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_P = 2'd1,
    BUSY_C = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic        romreq_r, romreq_s;
  logic [21:0] romaddr_r, romaddr_s;
  logic        promack_r, promack_s;
  logic        cromack_r, cromack_s;
  logic [7:0]  promdata_r, promdata_s;
  logic [7:0]  cromdata_r, cromdata_s;
  logic        last_r, last_s;   // 1 = CHR was granted last

`ifdef ROMARB_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          err_r, err_s;
`endif

  // Next-state and next-output computation for the arbitration FSM
  always_comb begin
    state_s    = state_r;
    romreq_s   = romreq_r;
    romaddr_s  = romaddr_r;
    promack_s  = 1'b0;
    cromack_s  = 1'b0;
    promdata_s = promdata_r;
    cromdata_s = cromdata_r;
    last_s     = last_r;
`ifdef ROMARB_TIMEOUT_EN
    cnt_s      = cnt_r;
    err_s      = err_r;
`endif
    case (state_r)
      IDLE: begin
        // PRG wins outright, or on a tie when CHR was served last
        if (bus.promreq && (!bus.cromreq || last_r)) begin
          romaddr_s = {1'b0, bus.promaddr};
          romreq_s  = 1'b1;
          last_s    = 1'b0;
          state_s   = BUSY_P;
`ifdef ROMARB_TIMEOUT_EN
          cnt_s     = '0;
`endif
        end else if (bus.cromreq) begin
          romaddr_s = {1'b1, bus.cromaddr};
          romreq_s  = 1'b1;
          last_s    = 1'b1;
          state_s   = BUSY_C;
`ifdef ROMARB_TIMEOUT_EN
          cnt_s     = '0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      BUSY_P, BUSY_C: begin
        if (bus.romack) begin
          romreq_s = 1'b0;
          state_s  = DONE;
          if (state_r == BUSY_P) begin
            promdata_s = bus.romdata;
            promack_s  = 1'b1;
          end else begin
            cromdata_s = bus.romdata;
            cromack_s  = 1'b1;
          end
        end else begin
`ifdef ROMARB_TIMEOUT_EN
          // Count reaches TIMEOUT-1 on the TIMEOUT-th busy cycle
          if (cnt_r == CW'(TIMEOUT - 1)) begin
            romreq_s = 1'b0;
            state_s  = DONE;
            err_s    = 1'b1;
            if (state_r == BUSY_P) begin
              promdata_s = 8'hFF;
              promack_s  = 1'b1;
            end else begin
              cromdata_s = 8'hFF;
              cromack_s  = 1'b1;
            end
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
`else
          state_s = state_r;
`endif
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s  = IDLE;
        romreq_s = 1'b0;
      end
    endcase
  end

  // State and registered-output update with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      romreq_r   <= 1'b0;
      romaddr_r  <= 22'h000000;
      promack_r  <= 1'b0;
      cromack_r  <= 1'b0;
      promdata_r <= 8'h00;
      cromdata_r <= 8'h00;
      last_r     <= 1'b1;
`ifdef ROMARB_TIMEOUT_EN
      cnt_r      <= '0;
      err_r      <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      romreq_r   <= romreq_s;
      romaddr_r  <= romaddr_s;
      promack_r  <= promack_s;
      cromack_r  <= cromack_s;
      promdata_r <= promdata_s;
      cromdata_r <= cromdata_s;
      last_r     <= last_s;
`ifdef ROMARB_TIMEOUT_EN
      cnt_r      <= cnt_s;
      err_r      <= err_s;
`endif
    end
  end

  assign bus.romreq   = romreq_r;
  assign bus.romaddr  = romaddr_r;
  assign bus.promack  = promack_r;
  assign bus.cromack  = cromack_r;
  assign bus.promdata = promdata_r;
  assign bus.cromdata = cromdata_r;
`ifdef ROMARB_TIMEOUT_EN
  assign bus.err      = err_r;
`else
  assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: requesters push expected data, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_rom_arbiter;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  rom_arbiter_if bus();

  rom_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  exp_p[$];
  logic [7:0]  exp_c[$];
  logic        grants[$];
  logic [7:0]  held_p = 8'h00, held_c = 8'h00;
  logic [7:0]  last_p_exp = 8'h00;
  int          promack_cnt = 0, cromack_cnt = 0;
  int          ack_cyc_p = 0, ack_cyc_c = 0;
  bit          mem_hold = 1'b0, fixed_en = 1'b0, stray_req = 1'b0, rand_delay = 1'b0;
  logic [7:0]  fixed_data = 8'h00;
  int          mem_delay = 0;
  logic [21:0] addr_at = 22'h0;
  int          req_hi = 0;

  // ROM image as seen by the memory model
  function automatic logic [7:0] rom_image(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {a[21:16], 2'b10} ^ 8'h5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Memory controller model: records grants, acks after a delay
  initial begin
    int  wait_cnt;
    int  cur_delay;
    bit  prev_req;
    wait_cnt = 0; cur_delay = 0; prev_req = 1'b0;
    bus.romack = 1'b0;
    bus.romdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      bus.romack = 1'b0;
      if (stray_req) begin
        bus.romack = 1'b1;
        bus.romdata = 8'h77;
        stray_req = 1'b0;
      end else if (bus.romreq) begin
        if (!prev_req) begin
          grants.push_back(bus.romaddr[21]);
          addr_at = bus.romaddr;
          wait_cnt = 0;
          req_hi = 1;
          cur_delay = rand_delay ? int'($urandom_range(0, 3)) : mem_delay;
        end else begin
          req_hi++;
          check("romaddr_stable", bus.romaddr, addr_at);
        end
        if (!mem_hold) begin
          if (wait_cnt >= cur_delay) begin
            bus.romack = 1'b1;
            bus.romdata = fixed_en ? fixed_data : rom_image(bus.romaddr);
          end else begin
            wait_cnt++;
          end
        end
      end
      prev_req = bus.romreq;
    end
  end

  // Monitor: pop expected data on each ack, otherwise check the data hold
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        held_p = 8'h00;
        held_c = 8'h00;
      end else begin
        if (bus.promack) begin
          promack_cnt++;
          if (exp_p.size() == 0) begin
            checks++; errors++;
            $display("FAIL promack_unexpected data=%0h", bus.promdata);
          end else begin
            e = exp_p.pop_front();
            check("promdata", bus.promdata, e);
            held_p = e;
          end
        end else begin
          check("promdata_hold", bus.promdata, held_p);
        end
        if (bus.cromack) begin
          cromack_cnt++;
          if (exp_c.size() == 0) begin
            checks++; errors++;
            $display("FAIL cromack_unexpected data=%0h", bus.cromdata);
          end else begin
            e = exp_c.pop_front();
            check("cromdata", bus.cromdata, e);
            held_c = e;
          end
        end else begin
          check("cromdata_hold", bus.cromdata, held_c);
        end
      end
    end
  end

  task automatic prg_access(input logic [20:0] a, input logic [7:0] e);
    bit got;
    got = 1'b0;
    bus.promaddr = a;
    bus.promreq = 1'b1;
    exp_p.push_back(e);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.promack) begin got = 1'b1; ack_cyc_p = cyc; last_p_exp = e; break; end
    end
    check("prg_ack_seen", got, 1'b1);
    @(posedge clk); #1;
    bus.promreq = 1'b0;
  endtask

  task automatic chr_access(input logic [20:0] a, input logic [7:0] e);
    bit got;
    got = 1'b0;
    bus.cromaddr = a;
    bus.cromreq = 1'b1;
    exp_c.push_back(e);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.cromack) begin got = 1'b1; ack_cyc_c = cyc; break; end
    end
    check("chr_ack_seen", got, 1'b1);
    @(posedge clk); #1;
    bus.cromreq = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int pa0, ca0;
    bit seen;
    logic [20:0] a;
    bus.promaddr = 21'h0; bus.promreq = 1'b0;
    bus.cromaddr = 21'h0; bus.cromreq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_romreq", bus.romreq, 1'b0);
    check("rst_romaddr", bus.romaddr, 22'h000000);
    check("rst_promack", bus.promack, 1'b0);
    check("rst_cromack", bus.cromack, 1'b0);
    check("rst_promdata", bus.promdata, 8'h00);
    check("rst_cromdata", bus.cromdata, 8'h00);
    check("rst_err", bus.err, 1'b0);
    reset = 1'b0;

    // Single PRG read with memory acking as soon as romreq is seen
    @(posedge clk); #1;
    fixed_en = 1'b1; fixed_data = 8'hA5; mem_delay = 0;
    t0 = cyc;
    prg_access(21'h00123, 8'hA5);
    check("prg_latency", ack_cyc_p - t0, 2);
    check("prg_romaddr", addr_at, 22'h000123);
    check("prg_no_cromack", cromack_cnt, 0);
    check("prg_one_ack", promack_cnt, 1);

    // Single CHR read
    fixed_data = 8'h3C;
    chr_access(21'h01FFF, 8'h3C);
    check("chr_romaddr", addr_at, 22'h201FFF);
    check("chr_one_ack", cromack_cnt, 1);
    fixed_en = 1'b0;

    // Contention from reset: strict alternation starting with PRG
    pulse_reset();
    grants.delete();
    fork
      begin
        for (int i = 0; i < 3; i++) prg_access(21'h00100 + 21'(i), rom_image({1'b0, 21'h00100 + 21'(i)}));
      end
      begin
        for (int i = 0; i < 3; i++) chr_access(21'h10200 + 21'(i), rom_image({1'b1, 21'h10200 + 21'(i)}));
      end
    join
    check("grant_count", grants.size(), 6);
    for (int i = 0; i < 6 && i < grants.size(); i++) check("grant_order", grants[i], i % 2);

    // Stray ack while idle must be ignored
    pa0 = promack_cnt; ca0 = cromack_cnt;
    stray_req = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check("stray_promack", promack_cnt, pa0);
    check("stray_cromack", cromack_cnt, ca0);
    check("stray_promdata", bus.promdata, last_p_exp);

    // Reset during a CHR access
    mem_hold = 1'b1;
    bus.cromaddr = 21'h0BEEF; bus.cromreq = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.romreq) begin seen = 1'b1; break; end
    end
    check("abort_romreq_up", seen, 1'b1);
    ca0 = cromack_cnt;
    #2 reset = 1'b1;
    #1;
    check("abort_romreq_async", bus.romreq, 1'b0);
    bus.cromreq = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    mem_hold = 1'b0;
    grants.delete();
    check("abort_no_cromack", cromack_cnt, ca0);
    fork
      prg_access(21'h05555, rom_image({1'b0, 21'h05555}));
      chr_access(21'h0AAAA, rom_image({1'b1, 21'h0AAAA}));
    join
    check("abort_tie_prg", (grants.size() > 0) ? grants[0] : 1'bx, 1'b0);

    // Randomized traffic with random memory latency
    rand_delay = 1'b1;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          logic [20:0] ra;
          ra = 21'($urandom);
          prg_access(ra, rom_image({1'b0, ra}));
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
      end
      begin
        for (int i = 0; i < 12; i++) begin
          logic [20:0] rc;
          rc = 21'($urandom);
          chr_access(rc, rom_image({1'b1, rc}));
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
      end
    join
    rand_delay = 1'b0;

    // Memory that never answers
    mem_hold = 1'b1;
    a = 21'h0ABCD;
`ifdef ROMARB_TIMEOUT_EN
    prg_access(a, 8'hFF);
    check("to_busy_cycles", req_hi, TO);
    check("to_err_set", bus.err, 1'b1);
    repeat (5) begin @(posedge clk); #1; end
    check("to_err_sticky", bus.err, 1'b1);
    mem_hold = 1'b0;
    pulse_reset();
    check("to_err_cleared", bus.err, 1'b0);
`else
    bus.promaddr = a; bus.promreq = 1'b1;
    repeat (1000) begin @(posedge clk); #1; end
    check("nto_romreq_held", bus.romreq, 1'b1);
    check("nto_req_cycles", (req_hi >= 999) ? 1 : 0, 1);
    check("nto_err", bus.err, 1'b0);
    bus.promreq = 1'b0;
    mem_hold = 1'b0;
    pulse_reset();
`endif

    repeat (3) begin @(posedge clk); #1; end
    check("exp_p_drained", exp_p.size(), 0);
    check("exp_c_drained", exp_c.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
